// File: rtl/ds_pkg.sv
// ds_pkg: shared definitions for the 1-Wire style byte framing layer.
//   BYTE_W    - bits per framed byte
//   CRC_POLY  - reflected Dallas CRC-8 polynomial (x^8+x^5+x^4+1)
//   ds_state_t- framing FSM states
//   crc8_step - one LSB-first bit update of the Dallas CRC-8
package ds_pkg;

    localparam int unsigned      BYTE_W   = 8;
    localparam logic [BYTE_W-1:0] CRC_POLY = 8'h8C;

    typedef enum logic [2:0] {
        IDLE,
        RST_ISS,
        RST_WAIT,
        WR_ISS,
        WR_WAIT,
        WR_LOAD,
        RD_ISS,
        RD_WAIT
    } ds_state_t;

    function automatic logic [BYTE_W-1:0] crc8_step(input logic [BYTE_W-1:0] crc,
                                                    input logic              din);
        logic fb;
        fb = crc[0] ^ din;
        return {1'b0, crc[BYTE_W-1:1]} ^ (fb ? CRC_POLY : '0);
    endfunction

endpackage

// File: rtl/ds_crc8.sv
// ds_crc8: serial Dallas CRC-8 accumulator, one wire bit per enabled cycle.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset, clears the register
//   clr  - synchronous clear at the start of a read
//   en   - fold din into the register this cycle
//   din  - received wire bit
//   crc  - current CRC register
module ds_crc8
    import ds_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic              din,
    output logic [BYTE_W-1:0] crc
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            crc <= '0;
        end else if (en) begin
            crc <= crc8_step(crc, din);
        end
    end

endmodule

// File: rtl/ds_intf_frame.sv
// ds_intf_frame: byte framing layer above a 1-Wire bit engine. Turns
// reset / write-N-bytes / read-N-bytes commands into a sequence of single
// bit commands, waiting for the bit engine's busy (rdy_bit low) then idle
// (rdy_bit high) handshake between every bit.
// Optional CRC check on reads: define DS_INTF_FRAME_CRC_EN.
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   rst_en, wr_en, rd_en      - one-cycle command requests (priority in that order)
//   len                       - byte count (0 -> 1, >MAX_BYTES -> MAX_BYTES)
//   wdata, wdata_vld          - write bytes; wdata_req asks for the next one
//   rdata, rdata_vld          - assembled read byte and its strobe
//   rdata_last, crc_ok        - final byte flag and CRC result on that byte
//   rdy                       - idle and no command present
//   rst_en_bit, wr_en_bit, wdata_bit, rd_en_bit - bit engine commands
//   rdata_bit, rdata_vld_bit, rdy_bit            - bit engine responses
module ds_intf_frame
    import ds_pkg::*;
#(
    parameter int unsigned MAX_BYTES = 9,
    parameter int unsigned LEN_W     = 4,
    parameter int unsigned LSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rst_en,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [LEN_W-1:0]  len,
    input  logic [BYTE_W-1:0] wdata,
    input  logic              wdata_vld,
    output logic              wdata_req,
    output logic [BYTE_W-1:0] rdata,
    output logic              rdata_vld,
    output logic              rdata_last,
    output logic              crc_ok,
    output logic              rdy,
    output logic              rst_en_bit,
    output logic              wr_en_bit,
    output logic              wdata_bit,
    output logic              rd_en_bit,
    input  logic              rdata_bit,
    input  logic              rdata_vld_bit,
    input  logic              rdy_bit
);

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BYTES);

    ds_state_t         state;
    logic [2:0]        bit_cnt;
    logic [LEN_W-1:0]  byte_cnt;
    logic [LEN_W-1:0]  len_q;
    logic [BYTE_W-1:0] shreg;
    logic              seen_low;

    logic [LEN_W-1:0]  len_eff;
    logic [2:0]        bit_pos;
    logic [BYTE_W-1:0] rd_byte;
    logic              bit_done;
    logic              byte_last;

    always_comb begin
        len_eff = len;
        if (len == '0) begin
            len_eff = LEN_W'(1);
        end else if (len > MAX_LEN) begin
            len_eff = MAX_LEN;
        end
        bit_pos          = (LSB_FIRST != 0) ? bit_cnt : 3'd7 - bit_cnt;
        // Shift register with the incoming wire bit merged in, so the final
        // byte can be presented without waiting another cycle.
        rd_byte          = shreg;
        rd_byte[bit_pos] = rdata_bit;
        // A bit completes only after the engine has been seen busy and is idle again.
        bit_done         = seen_low & rdy_bit;
        byte_last        = (byte_cnt == len_q - LEN_W'(1));
    end

    assign rdy = (state == IDLE) & ~rst_en & ~wr_en & ~rd_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            byte_cnt   <= '0;
            len_q      <= '0;
            shreg      <= '0;
            seen_low   <= 1'b0;
            wdata_req  <= 1'b0;
            rdata      <= '0;
            rdata_vld  <= 1'b0;
            rdata_last <= 1'b0;
            rst_en_bit <= 1'b0;
            wr_en_bit  <= 1'b0;
            wdata_bit  <= 1'b0;
            rd_en_bit  <= 1'b0;
        end else begin
            rst_en_bit <= 1'b0;
            wr_en_bit  <= 1'b0;
            rd_en_bit  <= 1'b0;
            wdata_req  <= 1'b0;
            rdata_vld  <= 1'b0;
            rdata_last <= 1'b0;

            case (state)
                IDLE: begin
                    bit_cnt  <= '0;
                    byte_cnt <= '0;
                    seen_low <= 1'b0;
                    if (rst_en) begin
                        state <= RST_ISS;
                    end else if (wr_en) begin
                        len_q <= len_eff;
                        shreg <= wdata;
                        state <= WR_ISS;
                    end else if (rd_en) begin
                        len_q <= len_eff;
                        shreg <= '0;
                        state <= RD_ISS;
                    end
                end

                RST_ISS: begin
                    if (rdy_bit) begin
                        rst_en_bit <= 1'b1;
                        seen_low   <= 1'b0;
                        state      <= RST_WAIT;
                    end
                end

                RST_WAIT: begin
                    if (!rdy_bit) seen_low <= 1'b1;
                    if (bit_done) state <= IDLE;
                end

                WR_ISS: begin
                    if (rdy_bit) begin
                        wr_en_bit <= 1'b1;
                        wdata_bit <= shreg[bit_pos];
                        seen_low  <= 1'b0;
                        state     <= WR_WAIT;
                    end
                end

                WR_WAIT: begin
                    if (!rdy_bit) seen_low <= 1'b1;
                    if (bit_done) begin
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            if (byte_last) begin
                                byte_cnt <= '0;
                                state    <= IDLE;
                            end else begin
                                byte_cnt  <= byte_cnt + LEN_W'(1);
                                wdata_req <= 1'b1;
                                state     <= WR_LOAD;
                            end
                        end else begin
                            state <= WR_ISS;
                        end
                    end
                end

                WR_LOAD: begin
                    if (wdata_vld) begin
                        shreg <= wdata;
                        state <= WR_ISS;
                    end
                end

                RD_ISS: begin
                    if (rdy_bit) begin
                        rd_en_bit <= 1'b1;
                        seen_low  <= 1'b0;
                        state     <= RD_WAIT;
                    end
                end

                RD_WAIT: begin
                    if (!rdy_bit) seen_low <= 1'b1;
                    // Capture and completion are independent: the engine may
                    // return the bit before or together with rdy_bit rising.
                    if (rdata_vld_bit) begin
                        shreg <= rd_byte;
                        if (bit_cnt == 3'd7) begin
                            rdata      <= rd_byte;
                            rdata_vld  <= 1'b1;
                            rdata_last <= byte_last;
                        end
                    end
                    if (bit_done) begin
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            if (byte_last) begin
                                byte_cnt <= '0;
                                state    <= IDLE;
                            end else begin
                                byte_cnt <= byte_cnt + LEN_W'(1);
                                state    <= RD_ISS;
                            end
                        end else begin
                            state <= RD_ISS;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

`ifdef DS_INTF_FRAME_CRC_EN
    logic [BYTE_W-1:0] crc;
    logic              crc_clr;
    logic              crc_en;

    assign crc_clr = (state == IDLE) & rd_en & ~rst_en & ~wr_en;
    assign crc_en  = (state == RD_WAIT) & rdata_vld_bit;

    ds_crc8 u_crc (
        .clk (clk),
        .rst (rst),
        .clr (crc_clr),
        .en  (crc_en),
        .din (rdata_bit),
        .crc (crc)
    );

    // The register already holds the final bit's update when the last
    // byte is strobed, so a zero residue means the frame checked out.
    assign crc_ok = rdata_last & (crc == '0);
`else
    assign crc_ok = 1'b1;
`endif

endmodule

// File: doc/ds_intf_frame.md
DS_INTF_FRAME -- requirements
Module: ds_intf_frame

Interface
REQ-001 SHALL have parameter MAX_BYTES, default 9, meaning maximum bytes per transfer (one full scratchpad read).
REQ-002 SHALL have parameter LEN_W, default 4, meaning width of the length field; must satisfy 2**LEN_W > MAX_BYTES.
REQ-003 SHALL have parameter LSB_FIRST, default 1, meaning 1 = bit 0 of each byte on the wire first, 0 = bit 7 first.
REQ-004 SHALL have: clk  in  1  single clock; all logic on its rising edge.
REQ-005 SHALL have: rst  in  1  reset, synchronous and active-high.
REQ-006 SHALL have: rst_en  in  1  one-cycle request for a bus reset pulse.
REQ-007 SHALL have: wr_en  in  1  one-cycle request to write len bytes.
REQ-008 SHALL have: rd_en  in  1  one-cycle request to read len bytes.
REQ-009 SHALL have: len  in  LEN_W  byte count, sampled with wr_en or rd_en.
REQ-010 SHALL have: wdata  in  8  write byte, sampled with wr_en (byte 0) and with wdata_vld (bytes 1..len-1).
REQ-011 SHALL have: wdata_vld  in  1  next write byte present on wdata.
REQ-012 SHALL have: wdata_req  out  1  one-cycle pulse requesting the next write byte.
REQ-013 SHALL have: rdata  out  8  assembled read byte.
REQ-014 SHALL have: rdata_vld  out  1  one-cycle strobe, rdata valid.
REQ-015 SHALL have: rdata_last  out  1  high with rdata_vld on the final byte.
REQ-016 SHALL have: crc_ok  out  1  CRC result, valid with rdata_last.
REQ-017 SHALL have: rdy  out  1  block idle; accepts a command this cycle.
REQ-018 SHALL have bit-layer ports rst_en_bit, wr_en_bit, wdata_bit, rd_en_bit (out, 1 bit each) and rdata_bit, rdata_vld_bit, rdy_bit (in, 1 bit each).

Function
REQ-019 SHALL implement an FSM with states IDLE, RST_ISS, RST_WAIT, WR_ISS, WR_WAIT, WR_LOAD, RD_ISS, RD_WAIT.
REQ-020 SHALL drive rdy = (state==IDLE) & ~rst_en & ~wr_en & ~rd_en, combinationally.
REQ-021 SHALL accept commands only in IDLE, with priority rst_en > wr_en > rd_en; lower-priority requests in the same cycle are dropped.
REQ-022 SHALL treat len=0 as 1 and len>MAX_BYTES as MAX_BYTES.
REQ-023 In each *_ISS state, SHALL pulse the matching *_en_bit for exactly one cycle in a cycle where rdy_bit=1, then enter *_WAIT.
REQ-024 In each *_WAIT state, SHALL wait for rdy_bit=0 and then rdy_bit=1 before leaving; the block never issues two bit commands back-to-back without this low-then-high sequence.
REQ-025 SHALL place wdata_bit in the same cycle as the wr_en_bit pulse and hold it until the next wr_en_bit pulse.
REQ-026 After bit 7 of a write byte, SHALL return to IDLE if it was the last byte; otherwise SHALL pulse wdata_req and enter WR_LOAD, stalling until wdata_vld=1.
REQ-027 In RD_WAIT, SHALL capture rdata_bit when rdata_vld_bit=1; bit position follows LSB_FIRST.
REQ-028 SHALL pulse rdata_vld one cycle after bit 7 of a read byte is captured; rdata SHALL hold its value until the next strobe.
REQ-029 SHALL return to IDLE from RST_WAIT, from the final WR_WAIT and from the final RD_WAIT; rdy SHALL be high in the cycle after return.
REQ-030 SHALL ignore rst_en, wr_en and rd_en while not in IDLE.
REQ-031 SHALL track bits with a 3-bit counter and bytes with a LEN_W-bit counter; both clear on transfer end.

Reset
REQ-032 When rst=1 at a clock edge, SHALL go to IDLE, clear both counters, and set all outputs to 0 except rdy, which SHALL follow REQ-020.
REQ-033 Reset mid-transfer SHALL abort the transfer without producing rdata_vld or wdata_req.

Configuration
REQ-034 Macro DS_INTF_FRAME_CRC_EN defined: SHALL compute the Dallas CRC-8 (x^8+x^5+x^4+1, init 0x00, LSB-first bitwise) over all read bits; crc_ok=1 with rdata_last when the final register is 0x00.
REQ-035 Macro DS_INTF_FRAME_CRC_EN undefined: SHALL contain no CRC logic and SHALL tie crc_ok to 1.

Structure
REQ-036 SHALL place the state enum, CRC polynomial constant 8'h8C and byte width 8 in shared package ds_pkg.
REQ-037 MAY place the CRC in sub-module ds_crc8 (ports: clk, rst, clr, en, din, crc).

Verification
REQ-038 Reset command, model rdy_bit low 5 cycles -> exactly one rst_en_bit pulse; rdy returns high after rdy_bit rises.
REQ-039 Write len=2, wdata=0xCC, then 0x44 given 3 cycles after wdata_req -> wr_en_bit pulses carry bits 0,0,1,1,0,0,1,1,0,0,1,0,0,0,1,0 with LSB_FIRST=1.
REQ-040 Read len=9 of scratchpad 50 05 4B 46 7F FF 0C 10 1C -> nine rdata_vld strobes, rdata_last on byte 9, crc_ok=1 with CRC enabled; corrupt one bit -> crc_ok=0.
REQ-041 rst_en and rd_en asserted in the same cycle -> only the reset runs; no rd_en_bit is issued.
REQ-042 rst asserted during byte 3 of a 9-byte read -> IDLE next cycle; no further strobes; a new read then completes normally.
REQ-043 len=0 write -> exactly 8 wr_en_bit pulses; len=15 read -> exactly 72 rd_en_bit pulses.
